// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and sequencer for the single-port data memory.
// One access in flight; the strobe cycle and the response pulse are both registered.
module dmem_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic              i_req0_we,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_wdata,
    output logic              o_rsp0_valid,
    output logic [DATA_W-1:0] o_rsp0_rdata,
    output logic              o_rsp0_err,

    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic              i_req1_we,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_wdata,
    output logic              o_rsp1_valid,
    output logic [DATA_W-1:0] o_rsp1_rdata,
    output logic              o_rsp1_err,

    output logic [ADDR_W-1:0] o_mem_r_addr,
    output logic [ADDR_W-1:0] o_mem_w_addr,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic              i_mem_valid,
    input  logic [DATA_W-1:0] i_mem_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 8);

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        RSP
    } state_t;

    typedef struct packed {
        logic              owner;
        logic              we;
        logic              err;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    state_t            state;
    logic              prio;
    logic              cmd_owner;
    logic              cmd_we;
    logic              cmd_err;

    logic              window;
    logic              grant0;
    logic              grant1;
    logic              accept;
    cmd_t              req;
    logic              mem_fail;
    logic [DATA_W-1:0] rsp_data;

    // Ready is a pure function of the valids, so a loser is told this cycle.
    always_comb begin
        window = i_rst_n && (state == IDLE || state == RSP);
        grant0 = i_req0_valid && (!prio || !i_req1_valid);
        grant1 = i_req1_valid && (prio || !i_req0_valid);
        accept = window && (grant0 || grant1);
    end

    assign o_req0_ready = window && grant0;
    assign o_req1_ready = window && grant1;

    always_comb begin
        req = '0;
        if (grant0) begin
            req.owner = 1'b0;
            req.we    = i_req0_we;
            req.addr  = i_req0_addr;
            req.wdata = i_req0_wdata;
        end else begin
            req.owner = 1'b1;
            req.we    = i_req1_we;
            req.addr  = i_req1_addr;
            req.wdata = i_req1_wdata;
        end
        req.err = (req.addr[2:0] != 3'd0) || (req.addr > LAST_ADDR);
    end

    always_comb begin
        mem_fail = cmd_err || !i_mem_valid;
        rsp_data = (mem_fail || cmd_we) ? '0 : i_mem_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            prio         <= 1'b0;
            cmd_owner    <= 1'b0;
            cmd_we       <= 1'b0;
            cmd_err      <= 1'b0;
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
            o_mem_r_addr <= '0;
            o_mem_w_addr <= '0;
            o_mem_data   <= '0;
            o_rsp0_valid <= 1'b0;
            o_rsp0_err   <= 1'b0;
            o_rsp0_rdata <= '0;
            o_rsp1_valid <= 1'b0;
            o_rsp1_err   <= 1'b0;
            o_rsp1_rdata <= '0;
        end else begin
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
            o_mem_r_addr <= '0;
            o_mem_w_addr <= '0;
            o_mem_data   <= '0;
            o_rsp0_valid <= 1'b0;
            o_rsp0_err   <= 1'b0;
            o_rsp0_rdata <= '0;
            o_rsp1_valid <= 1'b0;
            o_rsp1_err   <= 1'b0;
            o_rsp1_rdata <= '0;
            unique case (state)
                IDLE, RSP: begin
                    if (accept) begin
                        state     <= MEM;
                        prio      <= ~req.owner;
                        cmd_owner <= req.owner;
                        cmd_we    <= req.we;
                        cmd_err   <= req.err;
                        // Illegal addresses never reach the memory pins.
                        if (!req.err) begin
                            if (req.we) begin
                                o_mem_write  <= 1'b1;
                                o_mem_w_addr <= req.addr;
                                o_mem_data   <= req.wdata;
                            end else begin
                                o_mem_read   <= 1'b1;
                                o_mem_r_addr <= req.addr;
                            end
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MEM: begin
                    state <= RSP;
                    if (cmd_owner) begin
                        o_rsp1_valid <= 1'b1;
                        o_rsp1_err   <= mem_fail;
                        o_rsp1_rdata <= rsp_data;
                    end else begin
                        o_rsp0_valid <= 1'b1;
                        o_rsp0_err   <= mem_fail;
                        o_rsp0_rdata <= rsp_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a response scoreboard.
// A small memory model backs the DUT; expectations are hand-computed.
module tb_dmem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req0_valid = 1'b0;
    logic        o_req0_ready;
    logic        i_req0_we = 1'b0;
    logic [63:0] i_req0_addr = '0;
    logic [63:0] i_req0_wdata = '0;
    logic        o_rsp0_valid;
    logic [63:0] o_rsp0_rdata;
    logic        o_rsp0_err;
    logic        i_req1_valid = 1'b0;
    logic        o_req1_ready;
    logic        i_req1_we = 1'b0;
    logic [63:0] i_req1_addr = '0;
    logic [63:0] i_req1_wdata = '0;
    logic        o_rsp1_valid;
    logic [63:0] o_rsp1_rdata;
    logic        o_rsp1_err;
    logic [63:0] o_mem_r_addr;
    logic [63:0] o_mem_w_addr;
    logic [63:0] o_mem_data;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        i_mem_valid;
    logic [63:0] i_mem_data;

    logic        mem_ok = 1'b1;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          last_wr_cyc = -1;

    typedef struct {
        bit          owner;
        logic [63:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    localparam logic [63:0] WDAT = 64'h1122334455667788;

    dmem_arbiter dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req0_valid (i_req0_valid),
        .o_req0_ready (o_req0_ready),
        .i_req0_we    (i_req0_we),
        .i_req0_addr  (i_req0_addr),
        .i_req0_wdata (i_req0_wdata),
        .o_rsp0_valid (o_rsp0_valid),
        .o_rsp0_rdata (o_rsp0_rdata),
        .o_rsp0_err   (o_rsp0_err),
        .i_req1_valid (i_req1_valid),
        .o_req1_ready (o_req1_ready),
        .i_req1_we    (i_req1_we),
        .i_req1_addr  (i_req1_addr),
        .i_req1_wdata (i_req1_wdata),
        .o_rsp1_valid (o_rsp1_valid),
        .o_rsp1_rdata (o_rsp1_rdata),
        .o_rsp1_err   (o_rsp1_err),
        .o_mem_r_addr (o_mem_r_addr),
        .o_mem_w_addr (o_mem_w_addr),
        .o_mem_data   (o_mem_data),
        .o_mem_read   (o_mem_read),
        .o_mem_write  (o_mem_write),
        .i_mem_valid  (i_mem_valid),
        .i_mem_data   (i_mem_data)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [63:0] pat(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i);
    endfunction

    // Memory model: unwritten words read back a per-index pattern.
    logic [63:0] mem [128];
    bit          written [128];
    logic [6:0]  ridx;

    assign ridx        = o_mem_r_addr[9:3];
    assign i_mem_valid = mem_ok;
    assign i_mem_data  = o_mem_read ? (written[ridx] ? mem[ridx] : pat(int'(ridx))) : '0;

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (o_mem_write) begin
            mem[o_mem_w_addr[9:3]]     <= o_mem_data;
            written[o_mem_w_addr[9:3]] <= 1'b1;
        end
    end

    always @(negedge i_clk) begin
        if (o_mem_write) begin
            wr_cnt      <= wr_cnt + 1;
            last_wr_cyc <= cyc;
        end
        if (o_mem_read) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst_n && (o_rsp0_valid || o_rsp1_valid)) begin
            chk("rsp_one_owner", 64'(o_rsp0_valid & o_rsp1_valid), 64'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp0=%b rsp1=%b expected none", o_rsp0_valid, o_rsp1_valid);
            end else begin
                e = sb.pop_front();
                chk("rsp_owner", 64'(o_rsp1_valid), 64'(e.owner));
                chk("rsp_rdata", o_rsp1_valid ? o_rsp1_rdata : o_rsp0_rdata, e.rdata);
                chk("rsp_err", 64'(o_rsp1_valid ? o_rsp1_err : o_rsp0_err), 64'(e.err));
                chk("rsp_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic req(input bit n, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] erd,
                       input logic eerr, input bit push,
                       output int waited, output int hs);
        bit done;
        done   = 0;
        waited = -1;
        hs     = -1;
        if (n) begin
            i_req1_valid = 1'b1;
            i_req1_we    = we;
            i_req1_addr  = addr;
            i_req1_wdata = wdata;
        end else begin
            i_req0_valid = 1'b1;
            i_req0_we    = we;
            i_req0_addr  = addr;
            i_req0_wdata = wdata;
        end
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge i_clk);
            if ((n ? o_req1_ready : o_req0_ready) === 1'b1) begin
                done   = 1;
                waited = k;
                hs     = cyc;
                if (push) sb.push_back('{owner: n, rdata: erd, err: eerr, cyc: cyc + 2});
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL req%0d_timeout: got no ready expected ready within 40 cycles", n);
        end
        @(posedge i_clk);
        #1;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge i_clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_strobes"}, {62'd0, o_mem_read, o_mem_write}, 64'd0);
        chk({tag, "_addr"}, o_mem_r_addr | o_mem_w_addr | o_mem_data, 64'd0);
        chk({tag, "_rsp"}, {60'd0, o_rsp0_valid, o_rsp1_valid, o_rsp0_err, o_rsp1_err}, 64'd0);
        chk({tag, "_rdata"}, o_rsp0_rdata | o_rsp1_rdata, 64'd0);
        chk({tag, "_ready"}, {62'd0, o_req0_ready, o_req1_ready}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, hs, g, last, rc, wc;
        bit exp_owner;

        repeat (2) @(posedge i_clk);
        #1;
        chk_quiet("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Contention from reset: strict alternation starting at requester 0.
        i_req0_addr  = 64'h0;
        i_req1_addr  = 64'h8;
        i_req0_valid = 1'b1;
        i_req1_valid = 1'b1;
        exp_owner    = 0;
        g            = 0;
        last         = 0;
        for (int k = 0; k < 20 && g < 4; k++) begin
            @(negedge i_clk);
            if (o_req0_ready || o_req1_ready) begin
                chk("alt_grant", 64'(o_req1_ready), 64'(exp_owner));
                chk("alt_exclusive", 64'(o_req0_ready & o_req1_ready), 64'd0);
                if (g > 0) chk("alt_spacing", 64'(cyc - last), 64'd2);
                last = cyc;
                sb.push_back('{owner: o_req1_ready, rdata: o_req1_ready ? pat(1) : pat(0),
                               err: 1'b0, cyc: cyc + 2});
                exp_owner = ~exp_owner;
                g++;
            end
        end
        chk("alt_grant_count", 64'(g), 64'd4);
        @(posedge i_clk);
        #1;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        drain();

        // Write then read back through requester 0.
        wc = wr_cnt;
        req(0, 1'b1, 64'h10, WDAT, 64'd0, 1'b0, 1, w, hs);
        drain();
        chk("wr_strobe_cycles", 64'(wr_cnt - wc), 64'd1);
        chk("wr_strobe_at_T1", 64'(last_wr_cyc), 64'(hs + 1));
        req(0, 1'b0, 64'h10, 64'd0, WDAT, 1'b0, 1, w, hs);
        drain();

        // Misaligned and out-of-range accesses never touch the memory.
        rc = rd_cnt;
        wc = wr_cnt;
        req(1, 1'b0, 64'h13, 64'd0, 64'd0, 1'b1, 1, w, hs);
        req(1, 1'b0, 64'h3F9, 64'd0, 64'd0, 1'b1, 1, w, hs);
        req(1, 1'b1, 64'h3FC, 64'hDEAD, 64'd0, 1'b1, 1, w, hs);
        drain();
        chk("err_no_strobe", 64'((rd_cnt - rc) + (wr_cnt - wc)), 64'd0);
        req(1, 1'b0, 64'h3F8, 64'd0, pat(127), 1'b0, 1, w, hs);
        drain();

        // prio is 0 here; a lone requester 1 is still served at once.
        req(1, 1'b0, 64'h8, 64'd0, pat(1), 1'b0, 1, w, hs);
        chk("req1_immediate", 64'(w), 64'd0);
        drain();

        // Memory not reporting valid turns a legal read into an error.
        mem_ok = 1'b0;
        req(0, 1'b0, 64'h10, 64'd0, 64'd0, 1'b1, 1, w, hs);
        drain();
        mem_ok = 1'b1;

        // Reset while the write strobe is high.
        req(0, 1'b1, 64'h20, 64'hCAFE_F00D_0000_0001, 64'd0, 1'b0, 0, w, hs);
        chk("rstmid_strobe_on", 64'(o_mem_write), 64'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_quiet("rstmid");
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rstmid_no_write", 64'(written[4]), 64'd0);
        chk_quiet("rstmid_after");
        req(0, 1'b0, 64'h10, 64'd0, WDAT, 1'b0, 1, w, hs);
        chk("post_reset_immediate", 64'(w), 64'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
